// File: rtl/color_type_detector_pkg.sv
// ---------------------------------------------------------------------------
// color_type_detector_pkg
// Shared definitions for the color-type detector and the 7-seg display stage:
// the color codes, the pixel class codes, the detector FSM states, default
// tuning values and the RGB565 channel expansion helpers.
// ---------------------------------------------------------------------------
package color_type_detector_pkg;

  // Default tuning values, overridable through the top-level parameters
  localparam int         CNT_W_DEF         = 19;
  localparam logic [7:0] BLACK_TH_DEF      = 8'd48;
  localparam logic [7:0] WHITE_TH_DEF      = 8'd208;
  localparam logic [7:0] DOM_MARGIN_DEF    = 8'd40;
  localparam int         MIN_VOTES_DEF     = 1024;
  localparam int         STABLE_FRAMES_DEF = 2;

  // Color codes shared with the display stage. CLASS_NONE only ever appears
  // as a per-pixel class and is never committed to the output.
  typedef enum logic [2:0] {
    COLOR_INIT  = 3'd0,
    COLOR_BLACK = 3'd1,
    COLOR_WHITE = 3'd2,
    COLOR_RED   = 3'd3,
    COLOR_GREEN = 3'd4,
    COLOR_BLUE  = 3'd5,
    CLASS_NONE  = 3'd7
  } color_e;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_ACCUM  = 3'd1,
    S_FLUSH  = 3'd2,
    S_DECIDE = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  // Widen a 5-bit channel to 8 bits by replicating its top bits, so that
  // full scale maps to 8'hFF
  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  // Widen the 6-bit green channel to 8 bits the same way
  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

endpackage

// File: rtl/color_type_detector_if.sv
// ---------------------------------------------------------------------------
// color_type_detector_if
// Camera pixel stream into the detector and committed color code out.
//   frame_start  : 1-cycle pulse, start of frame
//   frame_end    : 1-cycle pulse, end of frame (after last pixel)
//   pix_valid    : pix_data valid this cycle
//   pix_data     : RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   color_type   : committed color code (color_e values)
//   color_update : 1-cycle pulse when color_type changes
// master = camera / stream source side, slave = detector side.
// ---------------------------------------------------------------------------
interface color_type_detector_if;

  logic        frame_start;
  logic        frame_end;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [2:0]  color_type;
  logic        color_update;

  modport master (
    output frame_start,
    output frame_end,
    output pix_valid,
    output pix_data,
    input  color_type,
    input  color_update
  );

  modport slave (
    input  frame_start,
    input  frame_end,
    input  pix_valid,
    input  pix_data,
    output color_type,
    output color_update
  );

endinterface

// File: rtl/pixel_color_classify.sv
// ---------------------------------------------------------------------------
// pixel_color_classify
// Classifies one RGB565 pixel per cycle into BLACK/WHITE/RED/GREEN/BLUE/NONE
// and registers the class together with its valid flag (1 clk latency).
//   clk          : system clock
//   rst          : synchronous active-high reset
//   pixValid_i   : pixel valid this cycle
//   pixData_i    : RGB565 pixel
//   classValid_o : registered valid
//   pixClass_o   : registered class (color_e, CLASS_NONE if no match)
// ---------------------------------------------------------------------------
module pixel_color_classify
  import color_type_detector_pkg::*;
#(
  parameter logic [7:0] BLACK_TH   = BLACK_TH_DEF,
  parameter logic [7:0] WHITE_TH   = WHITE_TH_DEF,
  parameter logic [7:0] DOM_MARGIN = DOM_MARGIN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixValid_i,
  input  logic [15:0] pixData_i,
  output logic        classValid_o,
  output color_e      pixClass_o
);

  // Channels are compared on 9 bits so channel + margin cannot wrap
  logic [8:0] r9, g9, b9;
  logic [8:0] maxRg, max9, minRg, min9;
  logic [8:0] margin9;
  color_e     class_d, class_q;
  logic       classValid_q;

  assign r9      = {1'b0, expand5(pixData_i[15:11])};
  assign g9      = {1'b0, expand6(pixData_i[10:5])};
  assign b9      = {1'b0, expand5(pixData_i[4:0])};
  assign margin9 = {1'b0, DOM_MARGIN};

  assign maxRg = (r9 > g9) ? r9 : g9;
  assign max9  = (maxRg > b9) ? maxRg : b9;
  assign minRg = (r9 < g9) ? r9 : g9;
  assign min9  = (minRg < b9) ? minRg : b9;

  // First matching class wins, in the order BLACK, WHITE, RED, GREEN, BLUE
  always_comb begin
    class_d = CLASS_NONE;
    if (max9 < {1'b0, BLACK_TH}) begin
      class_d = COLOR_BLACK;
    end else if (min9 > {1'b0, WHITE_TH}) begin
      class_d = COLOR_WHITE;
    end else if ((r9 > g9 + margin9) && (r9 > b9 + margin9)) begin
      class_d = COLOR_RED;
    end else if ((g9 > r9 + margin9) && (g9 > b9 + margin9)) begin
      class_d = COLOR_GREEN;
    end else if ((b9 > r9 + margin9) && (b9 > g9 + margin9)) begin
      class_d = COLOR_BLUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      classValid_q <= 1'b0;
      class_q      <= CLASS_NONE;
    end else begin
      classValid_q <= pixValid_i;
      class_q      <= class_d;
    end
  end

  assign classValid_o = classValid_q;
  assign pixClass_o   = class_q;

endmodule

// File: rtl/color_type_detector.sv
// ---------------------------------------------------------------------------
// color_type_detector
// Classifies every pixel of a camera frame, votes per frame, and commits a
// new color code once STABLE_FRAMES consecutive frames agree on the winner.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : color_type_detector_if.slave (pixel stream in, color code out)
// color_type changes exactly 3 clk after the edge that samples frame_end:
// S_FLUSH lets the last pixel land in its counter, S_DECIDE registers the
// winner, S_COMMIT updates the stability tracker and the output.
// ---------------------------------------------------------------------------
module color_type_detector
  import color_type_detector_pkg::*;
#(
  parameter int         CNT_W         = CNT_W_DEF,
  parameter logic [7:0] BLACK_TH      = BLACK_TH_DEF,
  parameter logic [7:0] WHITE_TH      = WHITE_TH_DEF,
  parameter logic [7:0] DOM_MARGIN    = DOM_MARGIN_DEF,
  parameter int         MIN_VOTES     = MIN_VOTES_DEF,
  parameter int         STABLE_FRAMES = STABLE_FRAMES_DEF
) (
  input logic             clk,
  input logic             rst,
  color_type_detector_if.slave bus
);

  localparam int SC_W = $clog2(STABLE_FRAMES + 1);

  state_e           state_q, state_d;
  logic             pixAccept;
  logic             classValid;
  color_e           pixClass;
  logic             clearVotes;
  logic [4:0]       voteHit;
  logic [CNT_W-1:0] voteCnt_q [5];
  logic [CNT_W-1:0] bestCnt;
  color_e           bestColor;
  logic             bestValid;
  color_e           winner_q;
  logic             winnerValid_q;
  color_e           candidate_q, candidate_d;
  logic [SC_W-1:0]  stableCnt_q, stableCnt_d;
  color_e           colorType_q, colorType_d;
  logic             colorUpdate_q, colorUpdate_d;

  // Pixels only enter the pipeline while a frame is being accumulated,
  // including the pixel that arrives together with frame_end
  assign pixAccept = bus.pix_valid && (state_q == S_ACCUM);

  pixel_color_classify #(
    .BLACK_TH   (BLACK_TH),
    .WHITE_TH   (WHITE_TH),
    .DOM_MARGIN (DOM_MARGIN)
  ) u_classify (
    .clk          (clk),
    .rst          (rst),
    .pixValid_i   (pixAccept),
    .pixData_i    (bus.pix_data),
    .classValid_o (classValid),
    .pixClass_o   (pixClass)
  );

  // Votes are cleared whenever a new frame begins: from idle, on an aborted
  // frame (frame_start without frame_end) and when a frame starts in the
  // same cycle as the commit. A clear also drops the pixel still in stage 1,
  // which belongs to the frame being discarded.
  assign clearVotes = bus.frame_start &&
                      ((state_q == S_WAIT) || (state_q == S_COMMIT) ||
                       ((state_q == S_ACCUM) && !bus.frame_end));

  // Which counter the stage-1 class lands in; CLASS_NONE hits none
  always_comb begin
    voteHit = '0;
    for (int i = 0; i < 5; i++) begin
      voteHit[i] = classValid && (pixClass == color_e'(3'(i + 1)));
    end
  end

  // Stage 2: saturating per-class vote counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst || clearVotes) begin
        voteCnt_q[i] <= '0;
      end else if (voteHit[i] && (voteCnt_q[i] != '1)) begin
        voteCnt_q[i] <= voteCnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Largest counter wins; strict compare keeps the lower code on a tie
  always_comb begin
    bestCnt   = voteCnt_q[0];
    bestColor = COLOR_BLACK;
    for (int i = 1; i < 5; i++) begin
      if (voteCnt_q[i] > bestCnt) begin
        bestCnt   = voteCnt_q[i];
        bestColor = color_e'(3'(i + 1));
      end
    end
    bestValid = (bestCnt >= CNT_W'(MIN_VOTES));
  end

  // Next state plus the stability tracker and output decisions
  always_comb begin
    state_d       = state_q;
    candidate_d   = candidate_q;
    stableCnt_d   = stableCnt_q;
    colorType_d   = colorType_q;
    colorUpdate_d = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (bus.frame_start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (bus.frame_end) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = bus.frame_start ? S_ACCUM : S_WAIT;
        if (!winnerValid_q) begin
          stableCnt_d = '0;
        end else begin
          if (winner_q == candidate_q) begin
            if (stableCnt_q != SC_W'(STABLE_FRAMES)) begin
              stableCnt_d = stableCnt_q + SC_W'(1);
            end
          end else begin
            candidate_d = winner_q;
            stableCnt_d = SC_W'(1);
          end
          if ((stableCnt_d == SC_W'(STABLE_FRAMES)) && (candidate_d != colorType_q)) begin
            colorType_d   = candidate_d;
            colorUpdate_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Winner register, stability tracker and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q      <= COLOR_INIT;
      winnerValid_q <= 1'b0;
      candidate_q   <= COLOR_INIT;
      stableCnt_q   <= '0;
      colorType_q   <= COLOR_INIT;
      colorUpdate_q <= 1'b0;
    end else begin
      if (state_q == S_DECIDE) begin
        winner_q      <= bestColor;
        winnerValid_q <= bestValid;
      end
      candidate_q   <= candidate_d;
      stableCnt_q   <= stableCnt_d;
      colorType_q   <= colorType_d;
      colorUpdate_q <= colorUpdate_d;
    end
  end

  assign bus.color_type   = colorType_q;
  assign bus.color_update = colorUpdate_q;

endmodule

// File: tb/tb_color_type_detector.sv
// ---------------------------------------------------------------------------
// tb_color_type_detector
// Directed scenarios for color_type_detector with hand-computed expectations.
// Inputs change on the falling edge; outputs are read on the falling edge.
// ---------------------------------------------------------------------------
module tb_color_type_detector;

  logic clk;
  logic rst;
  int   testsRun;
  int   failCount;

  color_type_detector_if bus ();

  color_type_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #2ms;
    $display("[TB] FAIL timeout: simulation did not finish, tests run %0d", testsRun);
    $fatal(1, "[TB] timeout");
  end

  // One falling-edge step with the given inputs
  task automatic drive(input logic fs, input logic fe, input logic pv, input logic [15:0] pd);
    @(negedge clk);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.pix_valid   = pv;
    bus.pix_data    = pd;
  endtask

  task automatic send_pixels(input logic [15:0] pd, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, pd);
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  // Drive frame_end (optionally with a pixel) and observe the outputs two
  // and three clocks later, plus the pulse one clock after that
  task automatic finish_frame(input logic pv, input logic [15:0] pd,
                              output logic [2:0] ctE2, output logic [2:0] ctE3,
                              output logic updE3, output logic updE4);
    drive(1'b0, 1'b1, pv, pd);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    ctE2 = bus.color_type;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    ctE3  = bus.color_type;
    updE3 = bus.color_update;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    updE4 = bus.color_update;
  endtask

  task automatic color_frame(input logic [15:0] pd, input int n,
                             output logic [2:0] ctE2, output logic [2:0] ctE3,
                             output logic updE3, output logic updE4);
    start_frame();
    send_pixels(pd, n);
    finish_frame(1'b0, 16'h0000, ctE2, ctE3, updE3, updE4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0000);
    testsRun++;
    if (bus.color_type !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL reset_color_type: got %0d expected 0", bus.color_type);
    end
    testsRun++;
    if (bus.color_update !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_color_update: got %0d expected 0", bus.color_update);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_red_commit();
    logic [2:0] e2, e3;
    logic u3, u4;
    color_frame(16'hF800, 2000, e2, e3, u3, u4);
    testsRun++;
    if (e3 !== 3'd0) begin failCount++; $display("[TB] FAIL red_f1_type: got %0d expected 0", e3); end
    testsRun++;
    if (u3 !== 1'b0) begin failCount++; $display("[TB] FAIL red_f1_update: got %0d expected 0", u3); end
    color_frame(16'hF800, 2000, e2, e3, u3, u4);
    testsRun++;
    if (e2 !== 3'd0) begin failCount++; $display("[TB] FAIL red_f2_early: got %0d expected 0", e2); end
    testsRun++;
    if (e3 !== 3'd3) begin failCount++; $display("[TB] FAIL red_f2_type: got %0d expected 3", e3); end
    testsRun++;
    if (u3 !== 1'b1) begin failCount++; $display("[TB] FAIL red_f2_update: got %0d expected 1", u3); end
    testsRun++;
    if (u4 !== 1'b0) begin failCount++; $display("[TB] FAIL red_f2_pulse_end: got %0d expected 0", u4); end
  endtask

  task automatic test_blue_change();
    logic [2:0] e2, e3;
    logic u3, u4;
    color_frame(16'h001F, 2000, e2, e3, u3, u4);
    testsRun++;
    if (e3 !== 3'd3) begin failCount++; $display("[TB] FAIL blue_f1_type: got %0d expected 3", e3); end
    testsRun++;
    if (u3 !== 1'b0) begin failCount++; $display("[TB] FAIL blue_f1_update: got %0d expected 0", u3); end
    color_frame(16'h001F, 2000, e2, e3, u3, u4);
    testsRun++;
    if (e2 !== 3'd3) begin failCount++; $display("[TB] FAIL blue_f2_early: got %0d expected 3", e2); end
    testsRun++;
    if (e3 !== 3'd5) begin failCount++; $display("[TB] FAIL blue_f2_type: got %0d expected 5", e3); end
    testsRun++;
    if (u3 !== 1'b1) begin failCount++; $display("[TB] FAIL blue_f2_update: got %0d expected 1", u3); end
    testsRun++;
    if (u4 !== 1'b0) begin failCount++; $display("[TB] FAIL blue_f2_pulse_end: got %0d expected 0", u4); end
  endtask

  // A red candidate with one vote, then a frame with no winner, then red
  // again: the empty frame must reset the streak so red is not committed
  task automatic test_no_winner();
    logic [2:0] e2, e3;
    logic u3, u4;
    color_frame(16'hF800, 2000, e2, e3, u3, u4);
    testsRun++;
    if (e3 !== 3'd5) begin failCount++; $display("[TB] FAIL nowin_red1_type: got %0d expected 5", e3); end
    start_frame();
    send_pixels(16'hFFFF, 500);
    send_pixels(16'h0000, 500);
    finish_frame(1'b0, 16'h0000, e2, e3, u3, u4);
    testsRun++;
    if (e3 !== 3'd5) begin failCount++; $display("[TB] FAIL nowin_type: got %0d expected 5", e3); end
    testsRun++;
    if (u3 !== 1'b0) begin failCount++; $display("[TB] FAIL nowin_update: got %0d expected 0", u3); end
    color_frame(16'hF800, 2000, e2, e3, u3, u4);
    testsRun++;
    if (e3 !== 3'd5) begin failCount++; $display("[TB] FAIL nowin_red2_type: got %0d expected 5", e3); end
    testsRun++;
    if (u3 !== 1'b0) begin failCount++; $display("[TB] FAIL nowin_red2_update: got %0d expected 0", u3); end
  endtask

  task automatic test_tie();
    logic [2:0] e2, e3;
    logic u3, u4;
    for (int f = 0; f < 2; f++) begin
      start_frame();
      send_pixels(16'h07E0, 1500);
      send_pixels(16'h001F, 1500);
      finish_frame(1'b0, 16'h0000, e2, e3, u3, u4);
      if (f == 0) begin
        testsRun++;
        if (e3 !== 3'd5) begin failCount++; $display("[TB] FAIL tie_f1_type: got %0d expected 5", e3); end
        testsRun++;
        if (u3 !== 1'b0) begin failCount++; $display("[TB] FAIL tie_f1_update: got %0d expected 0", u3); end
      end else begin
        testsRun++;
        if (e3 !== 3'd4) begin failCount++; $display("[TB] FAIL tie_f2_type: got %0d expected 4", e3); end
        testsRun++;
        if (u3 !== 1'b1) begin failCount++; $display("[TB] FAIL tie_f2_update: got %0d expected 1", u3); end
      end
    end
  endtask

  task automatic test_abort();
    logic [2:0] e2, e3;
    logic u3, u4;
    for (int f = 0; f < 2; f++) begin
      start_frame();
      send_pixels(16'hFFFF, 1800);
      start_frame();
      send_pixels(16'h0000, 2000);
      finish_frame(1'b0, 16'h0000, e2, e3, u3, u4);
      if (f == 0) begin
        testsRun++;
        if (e3 !== 3'd4) begin failCount++; $display("[TB] FAIL abort_f1_type: got %0d expected 4", e3); end
      end else begin
        testsRun++;
        if (e3 !== 3'd1) begin failCount++; $display("[TB] FAIL abort_f2_type: got %0d expected 1", e3); end
        testsRun++;
        if (u3 !== 1'b1) begin failCount++; $display("[TB] FAIL abort_f2_update: got %0d expected 1", u3); end
      end
    end
  endtask

  // 1023 pixels + 1 pixel on frame_end makes exactly MIN_VOTES; 1023 alone
  // falls short. Sequence full, short, full, full: only the last commits.
  task automatic test_min_votes();
    logic [2:0] e2, e3;
    logic u3, u4;
    logic [2:0] expType [4];
    expType[0] = 3'd1;
    expType[1] = 3'd1;
    expType[2] = 3'd1;
    expType[3] = 3'd2;
    for (int f = 0; f < 4; f++) begin
      start_frame();
      send_pixels(16'hFFFF, 1023);
      finish_frame((f != 1), 16'hFFFF, e2, e3, u3, u4);
      testsRun++;
      if (e3 !== expType[f]) begin
        failCount++;
        $display("[TB] FAIL minvotes_f%0d_type: got %0d expected %0d", f, e3, expType[f]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] e2, e3;
    logic u3, u4;
    start_frame();
    send_pixels(16'hF800, 1500);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    testsRun++;
    if (bus.color_type !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL midrst_type: got %0d expected 0", bus.color_type);
    end
    testsRun++;
    if (bus.color_update !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midrst_update: got %0d expected 0", bus.color_update);
    end
    rst = 1'b0;
    finish_frame(1'b0, 16'h0000, e2, e3, u3, u4);
    testsRun++;
    if (e3 !== 3'd0) begin failCount++; $display("[TB] FAIL midrst_stray_end_type: got %0d expected 0", e3); end
    testsRun++;
    if (u3 !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_stray_end_update: got %0d expected 0", u3); end
    color_frame(16'hF800, 2000, e2, e3, u3, u4);
    testsRun++;
    if (e3 !== 3'd0) begin failCount++; $display("[TB] FAIL midrst_f1_type: got %0d expected 0", e3); end
    color_frame(16'hF800, 2000, e2, e3, u3, u4);
    testsRun++;
    if (e3 !== 3'd3) begin failCount++; $display("[TB] FAIL midrst_f2_type: got %0d expected 3", e3); end
  endtask

  initial begin
    testsRun        = 0;
    failCount       = 0;
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 16'h0000;
    test_reset();
    test_red_commit();
    test_blue_change();
    test_no_winner();
    test_tie();
    test_abort();
    test_min_votes();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
